// File: rtl/cdr_rx_seq_if.sv
// Bit-stream input and MAC-side output bundle of the CDR receive sequencer.
// The sequencer takes the slave view; the CDR/MAC environment takes the master view.
interface cdr_rx_seq_if;
    logic       i_en;
    logic       i_data;
    logic       i_flag;
    logic       o_cdr_rst;
    logic       o_busy;
    logic [2:0] o_state;
    logic [6:0] o_len;
    logic       o_len_valid;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       o_done;
    logic       o_err;

    modport master (
        output i_en, i_data, i_flag,
        input  o_cdr_rst, o_busy, o_state, o_len, o_len_valid,
               o_byte, o_byte_valid, o_done, o_err
    );

    modport slave (
        input  i_en, i_data, i_flag,
        output o_cdr_rst, o_busy, o_state, o_len, o_len_valid,
               o_byte, o_byte_valid, o_done, o_err
    );
endinterface

// File: rtl/cdr_rx_seq.sv
// Receive sequencer: holds/releases the CDR, hunts preamble + SFD, captures the
// length field and delivers payload bytes; re-arms the CDR on timeout or framing error.
module cdr_rx_seq #(
    parameter int         RST_CYC = 4,
    parameter int         PRE_MIN = 24,
    parameter logic [7:0] SFD_VAL = 8'hA7,
    parameter int         SFD_WIN = 32,
    parameter int         TIMEOUT = 256
) (
    input  logic          i_clk,
    input  logic          i_rst,
    cdr_rx_seq_if.slave   io_rx
);
    localparam int ARM_W = $clog2(RST_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_PRE  = 3'd2,
        S_SFD  = 3'd3,
        S_LEN  = 3'd4,
        S_PAY  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_nxt;

    logic [ARM_W-1:0] r_arm;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_zc;
    logic [7:0]       r_sh;
    logic [7:0]       r_bc;
    logic [6:0]       r_nbytes;
    logic [6:0]       r_len;
    logic [7:0]       r_byte;
    logic             r_cdr_rst;
    logic             r_busy;
    logic             r_len_v;
    logic             r_byte_v;
    logic             r_done;
    logic             r_err;

    logic             w_act;
    logic             w_tmo;
    logic             w_bit;
    logic             w_chg;
    logic             w_byte_end;
    logic [7:0]       w_sh;
    logic [7:0]       w_zc_inc;
    logic [7:0]       w_bc_inc;
    logic [6:0]       w_nbytes_inc;
    logic             w_len_v;
    logic             w_byte_v;
    logic             w_err;

    // Bits are only consumed in the hunting/receiving states, and never on a
    // cycle already claimed by an enable drop or a timeout.
    assign w_act        = (r_state == S_PRE) || (r_state == S_SFD) ||
                          (r_state == S_LEN) || (r_state == S_PAY);
    assign w_tmo        = w_act && (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_bit        = w_act && io_rx.i_en && io_rx.i_flag && !w_tmo;
    assign w_sh         = {io_rx.i_data, r_sh[7:1]};
    assign w_zc_inc     = (r_zc == 8'hFF) ? r_zc : r_zc + 8'd1;
    assign w_bc_inc     = r_bc + 8'd1;
    assign w_byte_end   = (w_bc_inc == 8'd8);
    assign w_nbytes_inc = r_nbytes + 7'd1;
    assign w_chg        = (w_nxt != r_state);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (r_state != S_IDLE && !io_rx.i_en) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (io_rx.i_en) w_nxt = S_ARM;
                S_ARM:  if (r_arm == ARM_W'(RST_CYC - 1)) w_nxt = S_PRE;
                S_DONE: w_nxt = S_ARM;
                S_PRE: begin
                    if (w_tmo) w_nxt = S_ARM;
                    else if (w_bit && !io_rx.i_data && w_zc_inc == 8'(PRE_MIN))
                        w_nxt = S_SFD;
                end
                S_SFD: begin
                    if (w_tmo)                               w_nxt = S_ARM;
                    else if (w_bit && w_sh == SFD_VAL)        w_nxt = S_LEN;
                    else if (w_bit && w_bc_inc == 8'(SFD_WIN)) w_nxt = S_ARM;
                end
                S_LEN: begin
                    if (w_tmo) w_nxt = S_ARM;
                    else if (w_bit && w_byte_end)
                        w_nxt = (w_sh[6:0] == 7'd0) ? S_ARM : S_PAY;
                end
                S_PAY: begin
                    if (w_tmo) w_nxt = S_ARM;
                    else if (w_bit && w_byte_end && w_nbytes_inc == r_len)
                        w_nxt = S_DONE;
                end
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_len_v  = 1'b0;
        w_byte_v = 1'b0;
        w_err    = 1'b0;
        if (w_bit && w_byte_end) begin
            w_len_v  = (r_state == S_LEN);
            w_byte_v = (r_state == S_PAY);
        end
        if (io_rx.i_en) begin
            w_err = (w_tmo && (r_state == S_LEN || r_state == S_PAY)) ||
                    (w_len_v && w_sh[6:0] == 7'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_arm     <= '0;
            r_tmo     <= '0;
            r_zc      <= '0;
            r_sh      <= '0;
            r_bc      <= '0;
            r_nbytes  <= '0;
            r_len     <= '0;
            r_byte    <= '0;
            r_cdr_rst <= 1'b0;
            r_busy    <= 1'b0;
            r_len_v   <= 1'b0;
            r_byte_v  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_arm <= (r_state == S_ARM && !w_chg) ? r_arm + ARM_W'(1) : '0;
            r_tmo <= (w_chg || io_rx.i_flag || !w_act) ? '0 : r_tmo + TMO_W'(1);

            if (r_state == S_PRE && !w_chg) begin
                if (w_bit) r_zc <= io_rx.i_data ? 8'd0 : w_zc_inc;
            end else begin
                r_zc <= '0;
            end

            // Any state change drops a partially assembled byte.
            if (w_chg) begin
                r_sh <= '0;
                r_bc <= '0;
            end else if (w_bit && r_state != S_PRE) begin
                r_sh <= w_sh;
                r_bc <= (r_state != S_SFD && w_byte_end) ? 8'd0 : w_bc_inc;
            end

            if (r_state == S_PAY && !w_chg) begin
                if (w_byte_v) r_nbytes <= w_nbytes_inc;
            end else begin
                r_nbytes <= '0;
            end

            if (w_len_v)  r_len  <= w_sh[6:0];
            if (w_byte_v) r_byte <= w_sh;

            r_cdr_rst <= (w_nxt != S_IDLE) && (w_nxt != S_ARM);
            r_busy    <= (w_nxt != S_IDLE);
            r_len_v   <= w_len_v;
            r_byte_v  <= w_byte_v;
            r_done    <= (w_nxt == S_DONE);
            r_err     <= w_err;
        end
    end

    assign io_rx.o_state      = r_state;
    assign io_rx.o_cdr_rst    = r_cdr_rst;
    assign io_rx.o_busy       = r_busy;
    assign io_rx.o_len        = r_len;
    assign io_rx.o_len_valid  = r_len_v;
    assign io_rx.o_byte       = r_byte;
    assign io_rx.o_byte_valid = r_byte_v;
    assign io_rx.o_done       = r_done;
    assign io_rx.o_err        = r_err;
endmodule

// File: tb/tb_cdr_rx_seq.sv
// Scoreboard bench for cdr_rx_seq: stimulus pushes frame-level expected events,
// a negedge monitor pops and compares every pulse the sequencer presents.
module tb_cdr_rx_seq;
    localparam int K_LEN = 0, K_BYTE = 1, K_ERR = 2, K_DONE = 3;
    localparam int ST_IDLE = 0, ST_ARM = 1, ST_PRE = 2, ST_SFD = 3;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    cdr_rx_seq_if rx();

    cdr_rx_seq dut (.i_clk(i_clk), .i_rst(i_rst), .io_rx(rx));

    always #5 i_clk = ~i_clk;

    typedef struct { int kind; int val; } ev_t;
    ev_t exp_q[$];
    int  total = 0, bad = 0;
    int  last_low = 0, low_run = 0;
    int  gap_fix = 0;

    task automatic chk(string nm, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic pop_chk(int k, int v, string nm);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s unexpected pulse val=%0d (nothing expected)", nm, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                bad++;
                $display("FAIL %s got kind=%0d val=%0d exp kind=%0d val=%0d",
                         nm, k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: pulses checked in a fixed intra-cycle order; also measures how
    // long the CDR reset stays low each time the sequencer arms.
    always @(negedge i_clk) begin
        if (i_rst) begin
            if (rx.o_len_valid)  pop_chk(K_LEN,  int'(rx.o_len),  "len");
            if (rx.o_byte_valid) pop_chk(K_BYTE, int'(rx.o_byte), "byte");
            if (rx.o_err)        pop_chk(K_ERR,  0, "err");
            if (rx.o_done)       pop_chk(K_DONE, 0, "done");
            if (rx.o_busy && !rx.o_cdr_rst) low_run++;
            else begin
                if (low_run > 0) last_low = low_run;
                low_run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int next_gap();
        return (gap_fix > 0) ? gap_fix : int'($urandom_range(1, 6));
    endfunction

    // All drives happen 1 time unit after a rising edge.
    task automatic send_bit(logic b);
        int g;
        g = next_gap();
        rx.i_flag = 1'b0;
        repeat (g - 1) begin @(posedge i_clk); #1; rx.i_data = 1'($urandom_range(0, 1)); end
        rx.i_data = b;
        rx.i_flag = 1'b1;
        @(posedge i_clk); #1;
        rx.i_flag = 1'b0;
        rx.i_data = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_zeros(int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic cycles(int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic wait_state(int s, int budget, string nm);
        int n;
        n = 0;
        while (int'(rx.o_state) != s && n < budget) begin @(posedge i_clk); #1; n++; end
        chk(nm, int'(rx.o_state), s);
    endtask

    task automatic check_low(string nm);
        @(negedge i_clk); @(posedge i_clk); #1;
        chk(nm, last_low, 4);
    endtask

    // Reference model: what a well-formed frame must produce at the MAC side.
    task automatic expect_frame(logic [7:0] lenb, logic [7:0] pay[$]);
        int n;
        n = int'(lenb[6:0]);
        exp_q.push_back('{K_LEN, n});
        if (n == 0) exp_q.push_back('{K_ERR, 0});
        else begin
            for (int i = 0; i < n; i++) exp_q.push_back('{K_BYTE, int'(pay[i])});
            exp_q.push_back('{K_DONE, 0});
        end
    endtask

    logic [7:0] pay[$];
    logic [7:0] lb;
    int         nz, n;

    initial begin
        rx.i_en = 1'b0; rx.i_flag = 1'b0; rx.i_data = 1'b0;
        cycles(3);
        chk("rst_state",   int'(rx.o_state), ST_IDLE);
        chk("rst_cdr_rst", int'(rx.o_cdr_rst), 0);
        chk("rst_byte",    int'(rx.o_byte), 0);
        chk("rst_len",     int'(rx.o_len), 0);
        chk("rst_pulses",  int'({rx.o_len_valid, rx.o_byte_valid, rx.o_done, rx.o_err, rx.o_busy}), 0);
        i_rst = 1'b1;
        cycles(3);
        chk("idle_hold", int'(rx.o_state), ST_IDLE);

        // Nominal frame, fixed spacing of 5 cycles per strobe
        rx.i_en = 1'b1;
        last_low = 0;
        wait_state(ST_PRE, 20, "nom_reach_pre");
        check_low("nom_arm_low");
        gap_fix = 5;
        pay = '{8'h12, 8'h34, 8'h56};
        expect_frame(8'h03, pay);
        last_low = 0;
        send_zeros(32); send_byte(8'hA7); send_byte(8'h03);
        foreach (pay[i]) send_byte(pay[i]);
        chk("nom_len_hold", int'(rx.o_len), 3);
        chk("nom_byte_hold", int'(rx.o_byte), 8'h56);
        wait_state(ST_PRE, 40, "nom_rearm");
        check_low("nom_rearm_low");
        chk("nom_q_empty", exp_q.size(), 0);

        // Randomized frames
        gap_fix = 0;
        for (int f = 0; f < 6; f++) begin
            nz = $urandom_range(24, 40);
            lb = {1'($urandom_range(0, 1)), 7'($urandom_range(1, 5))};
            pay.delete();
            for (int i = 0; i < int'(lb[6:0]); i++) pay.push_back(8'($urandom));
            expect_frame(lb, pay);
            last_low = 0;
            send_zeros(nz); send_byte(8'hA7); send_byte(lb);
            foreach (pay[i]) send_byte(pay[i]);
            wait_state(ST_PRE, 40, "rnd_rearm");
            check_low("rnd_arm_low");
            chk("rnd_q_empty", exp_q.size(), 0);
        end

        // Broken preamble, then length byte with reserved bit set
        send_zeros(20); send_bit(1'b1); send_zeros(23);
        chk("brk_still_pre", int'(rx.o_state), ST_PRE);
        send_bit(1'b0);
        chk("brk_to_sfd", int'(rx.o_state), ST_SFD);
        pay.delete();
        for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
        expect_frame(8'h85, pay);
        send_byte(8'hA7); send_byte(8'h85);
        foreach (pay[i]) send_byte(pay[i]);
        chk("len85", int'(rx.o_len), 5);
        wait_state(ST_PRE, 40, "brk_rearm");
        chk("brk_q_empty", exp_q.size(), 0);

        // SFD never seen inside the window
        send_zeros(24);
        for (int i = 0; i < 31; i++) send_bit(1'(i % 2 == 0));
        chk("miss_still_sfd", int'(rx.o_state), ST_SFD);
        last_low = 0;
        send_bit(1'b0);
        chk("miss_to_arm", int'(rx.o_state), ST_ARM);
        wait_state(ST_PRE, 20, "miss_rearm");
        check_low("miss_arm_low");

        // Zero length: length pulse and error together, then re-arm
        pay.delete();
        expect_frame(8'h00, pay);
        send_zeros(24); send_byte(8'hA7); send_byte(8'h00);
        chk("zlen_to_arm", int'(rx.o_state), ST_ARM);
        wait_state(ST_PRE, 20, "zlen_rearm");
        chk("zlen_q_empty", exp_q.size(), 0);

        // Strobes stop two bits into the payload
        exp_q.push_back('{K_LEN, 2});
        exp_q.push_back('{K_ERR, 0});
        send_zeros(24); send_byte(8'hA7); send_byte(8'h02);
        send_bit(1'b1); send_bit(1'b0);
        n = 0;
        while (rx.o_err !== 1'b1 && n < 400) begin @(posedge i_clk); #1; n++; end
        chk("pay_tmo_window", int'(n >= 252 && n <= 260), 1);
        chk("pay_tmo_arm", int'(rx.o_state), ST_ARM);
        wait_state(ST_PRE, 20, "pay_tmo_rearm");
        chk("pay_tmo_q_empty", exp_q.size(), 0);

        // No strobes at all in preamble hunt: silent re-arm
        n = 0;
        while (int'(rx.o_state) != ST_ARM && n < 400) begin @(posedge i_clk); #1; n++; end
        chk("pre_tmo_window", int'(n >= 252 && n <= 260), 1);
        wait_state(ST_PRE, 20, "pre_tmo_rearm");

        // Enable drop mid-payload
        pay.delete();
        for (int i = 0; i < 4; i++) pay.push_back(8'($urandom));
        exp_q.push_back('{K_LEN, 4});
        exp_q.push_back('{K_BYTE, int'(pay[0])});
        exp_q.push_back('{K_BYTE, int'(pay[1])});
        send_zeros(24); send_byte(8'hA7); send_byte(8'h04);
        send_byte(pay[0]); send_byte(pay[1]);
        send_bit(pay[2][0]); send_bit(pay[2][1]); send_bit(pay[2][2]);
        rx.i_en = 1'b0;
        cycles(1);
        chk("endrop_idle", int'(rx.o_state), ST_IDLE);
        chk("endrop_cdr_rst", int'(rx.o_cdr_rst), 0);
        chk("endrop_busy", int'(rx.o_busy), 0);
        cycles(5);
        chk("endrop_q_empty", exp_q.size(), 0);
        rx.i_en = 1'b1;
        last_low = 0;
        wait_state(ST_PRE, 20, "endrop_rearm");
        check_low("endrop_arm_low");

        // Asynchronous reset mid-payload, off the clock edge
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back(8'($urandom) | 8'h01);
        exp_q.push_back('{K_LEN, 3});
        exp_q.push_back('{K_BYTE, int'(pay[0])});
        send_zeros(24); send_byte(8'hA7); send_byte(8'h03);
        send_byte(pay[0]); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(posedge i_clk); #3;
        i_rst = 1'b0;
        #1;
        chk("arst_state",   int'(rx.o_state), ST_IDLE);
        chk("arst_cdr_rst", int'(rx.o_cdr_rst), 0);
        chk("arst_byte",    int'(rx.o_byte), 0);
        chk("arst_len",     int'(rx.o_len), 0);
        chk("arst_pulses",  int'({rx.o_len_valid, rx.o_byte_valid, rx.o_done, rx.o_err, rx.o_busy}), 0);
        cycles(2);
        i_rst = 1'b1;
        last_low = 0;
        wait_state(ST_PRE, 20, "arst_rearm");
        check_low("arst_arm_low");
        chk("final_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
